// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings for the execute stage and its helpers: instruction
// codes, ALU-op and branch-condition function codes, the "no register" ID and
// the condition-code bundle.
package y86_pkg;

  localparam logic [3:0] RNONE        = 4'hF;

  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;  // also cmovXX
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3
  } alu_op_e;

  typedef enum logic [3:0] {
    C_ALWAYS = 4'h0,
    C_LE     = 4'h1,
    C_L      = 4'h2,
    C_E      = 4'h3,
    C_NE     = 4'h4,
    C_GE     = 4'h5,
    C_G      = 4'h6
  } cond_e;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational Y86-64 condition evaluator: (ZF, SF, OF, ifun) -> taken.
// Shared by the execute stage and the fetch-side branch predictor check.
module cond_eval
  import y86_pkg::*;
(
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  input  logic [3:0] ifun,
  output logic       cnd
);

  logic lt;

  assign lt = sf ^ of;

  // Decode the condition function; undefined codes are never taken.
  always_comb begin
    // NOTE: default assignment first so every path drives cnd and no latch is inferred.
    cnd = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | zf;
      C_L:      cnd = lt;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~zf;
      default:  cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/execute_cc_stage.sv
// Back half of the Y86-64 execute stage: derives ZF/SF/OF from the ALU result,
// holds the condition-code register, evaluates jXX/cmovXX conditions against
// the pre-update CC, and owns the E->M pipeline register with stall/bubble.
module execute_cc_stage
  import y86_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e_valid,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] alu_a,
  input  logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_res,
  input  logic [3:0]   e_dstE,
  input  logic         cc_block,
  input  logic         m_stall,
  input  logic         m_bubble,
  output logic         e_cnd,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         M_valid,
  output logic [3:0]   M_icode,
  output logic [W-1:0] M_valE,
  output logic [3:0]   M_dstE,
  output logic         M_cnd
);

  cc_t  cc_q;
  cc_t  cc_new;
  logic cc_we;
  logic cond_raw;
  logic a_msb, b_msb, r_msb;

  // Only the sign bits of the operands matter for overflow detection.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{alu_a[W-2:0], alu_b[W-2:0]};

  assign a_msb = alu_a[W-1];
  assign b_msb = alu_b[W-1];
  assign r_msb = alu_res[W-1];

  // Flags for the instruction currently in E, taken from the ALU's own result.
  always_comb begin
    cc_new.zf = (alu_res == '0);
    cc_new.sf = r_msb;
    cc_new.of = 1'b0;
    case (e_ifun)
      ALU_ADD: cc_new.of = (a_msb == b_msb) && (r_msb != a_msb);
      ALU_SUB: cc_new.of = (a_msb != b_msb) && (r_msb != b_msb);
      default: cc_new.of = 1'b0;
    endcase
  end

  // A stalled M stage means the OPq has not really retired from E yet, so the
  // CC must not move either; a faulting later stage also freezes the flags.
  assign cc_we = e_valid && (e_icode == ICODE_OPQ) && !cc_block && !m_stall;

  // Condition-code register, reset to "result was zero".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
    end else if (cc_we) begin
      // NOTE: non-blocking so every register in this stage samples pre-edge values.
      cc_q <= cc_new;
    end
  end

  assign cc_zf = cc_q.zf;
  assign cc_sf = cc_q.sf;
  assign cc_of = cc_q.of;

  // Conditions always see the stored CC, never the flags being produced now.
  cond_eval u_cond_eval (
    .zf   (cc_q.zf),
    .sf   (cc_q.sf),
    .of   (cc_q.of),
    .ifun (e_ifun),
    .cnd  (cond_raw)
  );

  assign e_cnd = ((e_icode == ICODE_JXX) || (e_icode == ICODE_RRMOVQ)) ? cond_raw : 1'b1;

  // E->M pipeline register: stall holds, bubble or an empty slot loads a NOP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      M_valid <= 1'b0;
      M_icode <= ICODE_NOP;
      M_valE  <= '0;
      M_dstE  <= RNONE;
      M_cnd   <= 1'b0;
    end else if (m_stall) begin
      M_valid <= M_valid;
    end else if (m_bubble || !e_valid) begin
      M_valid <= 1'b0;
      M_icode <= ICODE_NOP;
      M_valE  <= '0;
      M_dstE  <= RNONE;
      M_cnd   <= 1'b0;
    end else begin
      M_valid <= 1'b1;
      M_icode <= e_icode;
      M_valE  <= alu_res;
      M_cnd   <= e_cnd;
      M_dstE  <= ((e_icode == ICODE_RRMOVQ) && !e_cnd) ? RNONE : e_dstE;
    end
  end

  // Stall and bubble together is an upstream control bug; stall wins above.
  assert property (@(posedge clk) disable iff (!rst_n) !(m_stall && m_bubble))
    else $error("execute_cc_stage: m_stall and m_bubble asserted together");

endmodule
